// File: rtl/cheshire_rst_seq.sv
// Board reset and boot-strap sequencer: synchronises and debounces the reset button,
// waits for PLL lock, holds the SoC in reset and latches boot straps on release.
// Optional feature macro: CHESHIRE_RST_SEQ_LOCK_LOSS_EN (lock loss in RUN re-enters WAIT_LOCK).
module cheshire_rst_seq #(
   parameter int unsigned SyncStages     = 2,
   parameter int unsigned DebounceCycles = 1000,
   parameter int unsigned HoldCycles     = 256
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       pll_locked_i,
   input  logic       btn_reset_i,
   input  logic       vio_reset_i,
   input  logic [1:0] boot_mode_i,
   output logic       soc_rst_no,
   output logic [1:0] boot_mode_o,
   output logic [1:0] state_o,
   output logic [7:0] rst_count_o
);

   localparam int unsigned DbW   = $clog2(DebounceCycles + 1);
   localparam int unsigned HoldW = $clog2(HoldCycles + 1);

`ifdef CHESHIRE_RST_SEQ_LOCK_LOSS_EN
   localparam bit LockLossEn = 1'b1;
`else
   localparam bit LockLossEn = 1'b0;
`endif

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2,
      UNUSED    = 2'd3
   } state_e;

   // Elaboration-time parameter sanity
   if (SyncStages < 2) begin : g_bad_sync
      $error("cheshire_rst_seq: SyncStages must be >= 2");
   end
   if (DebounceCycles < 1) begin : g_bad_db
      $error("cheshire_rst_seq: DebounceCycles must be >= 1");
   end
   if (HoldCycles < 1) begin : g_bad_hold
      $error("cheshire_rst_seq: HoldCycles must be >= 1");
   end

   logic [SyncStages-1:0] btn_sync_q, btn_sync_d;
   logic [SyncStages-1:0] lock_sync_q, lock_sync_d;
   logic                  btn_synced;
   logic                  lock_synced;

   logic                  btn_db_q, btn_db_d;
   logic [DbW-1:0]        db_cnt_q, db_cnt_d;

   state_e                state_q, state_d;
   logic [HoldW-1:0]      hold_cnt_q, hold_cnt_d;
   logic [1:0]            boot_mode_q, boot_mode_d;
   logic [7:0]            rst_count_q, rst_count_d;
   logic                  req;

   // Synchroniser chains: new sample enters bit 0, synced value leaves the top bit
   always_comb begin
      btn_sync_d  = {btn_sync_q[SyncStages-2:0], btn_reset_i};
      lock_sync_d = {lock_sync_q[SyncStages-2:0], pll_locked_i};
   end

   assign btn_synced  = btn_sync_q[SyncStages-1];
   assign lock_synced = lock_sync_q[SyncStages-1];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         btn_sync_q  <= '0;
         lock_sync_q <= '0;
      end else begin
         btn_sync_q  <= btn_sync_d;
         lock_sync_q <= lock_sync_d;
      end
   end

   // Debouncer: the value flips only after DebounceCycles consecutive differing cycles
   always_comb begin
      btn_db_d = btn_db_q;
      db_cnt_d = db_cnt_q;
      if (btn_synced != btn_db_q) begin
         if (db_cnt_q == DbW'(DebounceCycles - 1)) begin
            btn_db_d = btn_synced;
            db_cnt_d = '0;
         end else begin
            db_cnt_d = db_cnt_q + DbW'(1);
         end
      end else begin
         db_cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         btn_db_q <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         btn_db_q <= btn_db_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   assign req = btn_db_q | vio_reset_i;

   // Sequencer next state: lock loss beats a reset request, which beats the hold count
   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      boot_mode_d = boot_mode_q;
      rst_count_d = rst_count_q;
      unique case (state_q)
         WAIT_LOCK: begin
            if (lock_synced) begin
               state_d    = HOLD;
               hold_cnt_d = '0;
            end
         end
         HOLD: begin
            if (!lock_synced) begin
               state_d = WAIT_LOCK;
            end else if (req) begin
               hold_cnt_d = '0;
            end else if (hold_cnt_q == HoldW'(HoldCycles - 1)) begin
               state_d     = RUN;
               boot_mode_d = boot_mode_i;
               if (rst_count_q != 8'hFF) begin
                  rst_count_d = rst_count_q + 8'd1;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + HoldW'(1);
            end
         end
         RUN: begin
            if (LockLossEn && !lock_synced) begin
               state_d = WAIT_LOCK;
            end else if (req) begin
               state_d    = HOLD;
               hold_cnt_d = '0;
            end
         end
         default: begin
            state_d = WAIT_LOCK;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= WAIT_LOCK;
         hold_cnt_q  <= '0;
         boot_mode_q <= 2'b00;
         rst_count_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         boot_mode_q <= boot_mode_d;
         rst_count_q <= rst_count_d;
      end
   end

   // Release decoded straight from the state register so it cannot glitch
   assign soc_rst_no  = (state_q == RUN);
   assign boot_mode_o = boot_mode_q;
   assign state_o     = state_q;
   assign rst_count_o = rst_count_q;

endmodule
